// File: rtl/axis_slv_pkg.sv
// Shared constants and helpers for the AXI-Stream slave buffer.
// Beat layout in FIFO storage, MSB first: {keep, last, user, data}.
package axis_slv_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int USER_W_DEF = 2;
  localparam int DEPTH_DEF  = 4;

  // Level counter must hold 0..depth inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Width of one stored beat: keep + last + user + data.
  function automatic int beat_w(input int data_w, input int user_w);
    return (data_w / 8) + 1 + user_w + data_w;
  endfunction

  // Beat record at the default widths.
  typedef struct packed {
    logic [DATA_W_DEF/8-1:0] keep;
    logic                    last;
    logic [USER_W_DEF-1:0]   user;
    logic [DATA_W_DEF-1:0]   data;
  } beat_t;

endpackage

// File: rtl/axis_slave_buf_if.sv
// Bundle of the upstream AXIS channel, the backend valid/ready port and status.
// slave modport is the buffer's view; master is the driver/observer view.
interface axis_slave_buf_if #(
  parameter int DATA_W = 32,
  parameter int USER_W = 2,
  parameter int DEPTH  = 4
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              axis_tvalid;
  logic [DATA_W-1:0] axis_tdata;
  logic [KEEP_W-1:0] axis_tstrb;
  logic [KEEP_W-1:0] axis_tkeep;
  logic              axis_tlast;
  logic [USER_W-1:0] axis_tuser;
  logic              axis_tready;

  logic [DATA_W-1:0] bk_data;
  logic [KEEP_W-1:0] bk_keep;
  logic              bk_last;
  logic [USER_W-1:0] bk_user;
  logic              bk_valid;
  logic              bk_ready;

  logic [LVL_W-1:0]  fifo_level;
  logic [15:0]       pkt_cnt;

  modport slave (
    input  axis_tvalid, axis_tdata, axis_tstrb, axis_tkeep, axis_tlast, axis_tuser,
    output axis_tready,
    output bk_data, bk_keep, bk_last, bk_user, bk_valid,
    input  bk_ready,
    output fifo_level, pkt_cnt
  );

  modport master (
    output axis_tvalid, axis_tdata, axis_tstrb, axis_tkeep, axis_tlast, axis_tuser,
    input  axis_tready,
    input  bk_data, bk_keep, bk_last, bk_user, bk_valid,
    output bk_ready,
    input  fifo_level, pkt_cnt
  );
endinterface

// File: rtl/axis_slv_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Head entry is always visible on rdata_o; storage is not reset.
module axis_slv_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [LVL_W-1:0] level_o,
  output logic [LVL_W-1:0] level_d_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             wr_en, rd_en;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign wr_en   = push_i & ~full_o;
  assign rd_en   = pop_i & ~empty_o;

  // Occupancy after this cycle's push/pop; a simultaneous pair cancels.
  always_comb begin
    level_d = level_q + LVL_W'(wr_en) - LVL_W'(rd_en);
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Storage write; left unreset so it maps onto plain registers/RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o   = mem_q[rd_ptr_q];
  assign level_o   = level_q;
  assign level_d_o = level_d;
endmodule

// File: rtl/axis_slave_buf.sv
// AXI-Stream slave front end: buffers upstream beats (data/keep/last/user)
// in a FWFT FIFO and presents the head beat on a backend valid/ready port.
// tready is registered from the next-cycle level, so it has no combinational
// path from tvalid or bk_ready; at full this costs one bubble after a pop.
// Optional build macro AXIS_SLV_PKT_CNT_EN enables the popped-packet counter.
module axis_slave_buf
  import axis_slv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int USER_W = USER_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic             axi_aclk,
  input  logic             axi_aresetn,
  axis_slave_buf_if.slave  bus
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int LVL_W  = lvl_w(DEPTH);
  localparam int BEAT_W = beat_w(DATA_W, USER_W);

  logic              tready_q, tready_d;
  logic              push, pop;
  logic [BEAT_W-1:0] wr_beat, rd_beat;
  logic [LVL_W-1:0]  level, level_next;
  logic              full, empty;
  logic              head_last;

  // Position bytes are not supported; tstrb is intentionally dropped.
  logic              unused_strb;
  assign unused_strb = ^bus.axis_tstrb;

  assign push    = bus.axis_tvalid & tready_q;
  assign pop     = ~empty & bus.bk_ready;
  assign wr_beat = {bus.axis_tkeep, bus.axis_tlast, bus.axis_tuser, bus.axis_tdata};

  axis_slv_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (axi_aclk),
    .rst_ni    (axi_aresetn),
    .push_i    (push),
    .pop_i     (pop),
    .wdata_i   (wr_beat),
    .rdata_o   (rd_beat),
    .level_o   (level),
    .level_d_o (level_next),
    .full_o    (full),
    .empty_o   (empty)
  );

  // Ready for the next cycle whenever that cycle will not start full.
  always_comb begin
    tready_d = (level_next != LVL_W'(DEPTH));
  end

  // Registered upstream ready; low in reset, high one clock after release.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) tready_q <= 1'b0;
    else              tready_q <= tready_d;
  end

  assign head_last = rd_beat[DATA_W+USER_W];

  // Head beat is zeroed while empty so unreset storage never shows on the bus.
  assign bus.axis_tready = tready_q;
  assign bus.bk_valid    = ~empty;
  assign bus.bk_data     = empty ? '0   : rd_beat[DATA_W-1:0];
  assign bus.bk_user     = empty ? '0   : rd_beat[DATA_W +: USER_W];
  assign bus.bk_last     = empty ? 1'b0 : head_last;
  assign bus.bk_keep     = empty ? '0   : rd_beat[DATA_W+USER_W+1 +: KEEP_W];
  assign bus.fifo_level  = level;

`ifdef AXIS_SLV_PKT_CNT_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  // Count packets as their last beat leaves; wraps at 16 bits.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q + 16'(pop & head_last);
  end

  // Packet counter register.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) pkt_cnt_q <= '0;
    else              pkt_cnt_q <= pkt_cnt_d;
  end

  assign bus.pkt_cnt = pkt_cnt_q;
`else
  assign bus.pkt_cnt = 16'h0;
`endif

  logic unused_full;
  assign unused_full = full;
endmodule

// File: tb/tb_axis_slave_buf.sv
// Directed bench for axis_slave_buf: reset, streaming, fill/drain, full+pop,
// sidebands and pointer wrap against a reference queue of expected beats.
// Inputs change and outputs are checked on the falling clock edge.
module tb_axis_slave_buf;
  import axis_slv_pkg::*;

  localparam int DW = DATA_W_DEF;
  localparam int UW = USER_W_DEF;
  localparam int DP = DEPTH_DEF;

  logic axi_aclk    = 1'b0;
  logic axi_aresetn = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  axis_slave_buf_if #(.DATA_W(DW), .USER_W(UW), .DEPTH(DP)) ifc ();

  axis_slave_buf #(.DATA_W(DW), .USER_W(UW), .DEPTH(DP)) dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .bus         (ifc)
  );

  int          n_chk = 0;
  int          n_err = 0;
  beat_t       m_q[$];
  logic        m_tready = 1'b0;
  logic [15:0] m_pkt    = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_pkt();
`ifdef AXIS_SLV_PKT_CNT_EN
    return m_pkt;
`else
    return 16'h0;
`endif
  endfunction

  // Called at a falling edge: drive, predict the rising edge, advance, check.
  task automatic step(input logic tv, input logic [31:0] d, input logic [3:0] k,
                      input logic l, input logic [1:0] u, input logic br, output logic acc);
    logic  push, pop;
    beat_t b;
    ifc.axis_tvalid = tv;
    ifc.axis_tdata  = d;
    ifc.axis_tkeep  = k;
    ifc.axis_tstrb  = ~k;
    ifc.axis_tlast  = l;
    ifc.axis_tuser  = u;
    ifc.bk_ready    = br;
    push = tv & m_tready;
    pop  = (m_q.size() != 0) & br;
    if (m_q.size() != 0) begin
      chk("bk_data", 64'(ifc.bk_data), 64'(m_q[0].data));
      chk("bk_keep", 64'(ifc.bk_keep), 64'(m_q[0].keep));
      chk("bk_last", 64'(ifc.bk_last), 64'(m_q[0].last));
      chk("bk_user", 64'(ifc.bk_user), 64'(m_q[0].user));
    end
    if (pop) begin
      if (m_q[0].last) m_pkt++;
      void'(m_q.pop_front());
    end
    if (push) begin
      b.data = d; b.keep = k; b.last = l; b.user = u;
      m_q.push_back(b);
    end
    acc = push;
    @(negedge axi_aclk);
    m_tready = (m_q.size() != DP);
    chk("level",    64'(ifc.fifo_level),  64'(m_q.size()));
    chk("tready",   64'(ifc.axis_tready), 64'(m_tready));
    chk("bk_valid", 64'(ifc.bk_valid),    64'(m_q.size() != 0));
    chk("pkt_cnt",  64'(ifc.pkt_cnt),     64'(exp_pkt()));
  endtask

  // Assert reset at a falling edge, check the cleared state, release.
  task automatic do_reset();
    logic acc;
    axi_aresetn     = 1'b0;
    ifc.axis_tvalid = 1'b0;
    ifc.bk_ready    = 1'b0;
    #1;
    m_q.delete();
    m_tready = 1'b0;
    m_pkt    = '0;
    chk("rst_level",    64'(ifc.fifo_level),  0);
    chk("rst_bk_valid", 64'(ifc.bk_valid),    0);
    chk("rst_tready",   64'(ifc.axis_tready), 0);
    chk("rst_bk_data",  64'(ifc.bk_data),     0);
    chk("rst_bk_side",  64'({ifc.bk_keep, ifc.bk_last, ifc.bk_user}), 0);
    chk("rst_pkt_cnt",  64'(ifc.pkt_cnt),     0);
    repeat (2) @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    step(0, 0, 0, 0, 0, 0, acc);
    chk("rst_rel_tready", 64'(ifc.axis_tready), 1);
  endtask

  initial begin
    logic acc;
    int   sent, cyc;
    ifc.axis_tvalid = 0; ifc.axis_tdata = '0; ifc.axis_tkeep = '0; ifc.axis_tstrb = '0;
    ifc.axis_tlast  = 0; ifc.axis_tuser = '0; ifc.bk_ready = 0;
    @(negedge axi_aclk);
    do_reset();

    // Streaming: 16 beats back to back, 1 beat per clock, level never above 1.
    sent = 0; cyc = 0;
    while ((sent < 16 || m_q.size() != 0) && cyc < 40) begin
      step(sent < 16, 32'(sent), 4'hF, 0, 2'd0, 1, acc);
      if (acc) sent++;
      cyc++;
      chk("stream_lvl_le1", 64'(ifc.fifo_level <= 1), 1);
    end
    chk("stream_cycles", 64'(cyc), 17);

    // Fill: 6 offered with backend stalled, only DEPTH accepted.
    sent = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 32'(100 + sent), 4'hF, 0, 2'd0, 0, acc);
      if (acc) sent++;
    end
    chk("fill_accepted", 64'(sent), 4);
    chk("fill_level",    64'(ifc.fifo_level), 4);
    chk("fill_tready",   64'(ifc.axis_tready), 0);
    cyc = 0;
    while ((sent < 6 || m_q.size() != 0) && cyc < 30) begin
      step(sent < 6, 32'(100 + sent), 4'hF, 0, 2'd0, 1, acc);
      if (acc) sent++;
      cyc++;
    end
    chk("fill_drained", 64'(sent == 6 && m_q.size() == 0), 1);

    // Full + single pop, then simultaneous push and pop.
    for (int i = 0; i < 4; i++) step(1, 32'(200 + i), 4'hF, 0, 2'd0, 0, acc);
    chk("full_level", 64'(ifc.fifo_level), 4);
    step(0, 0, 0, 0, 0, 1, acc);
    chk("fullpop_level",  64'(ifc.fifo_level), 3);
    chk("fullpop_tready", 64'(ifc.axis_tready), 1);
    step(1, 32'h0000_0300, 4'hF, 0, 2'd0, 1, acc);
    chk("pushpop_level", 64'(ifc.fifo_level), 3);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1, acc);
    chk("fullpop_empty", 64'(ifc.bk_valid), 0);

    // Reset in the middle of a stream with three beats buffered.
    for (int i = 0; i < 3; i++) step(1, 32'(400 + i), 4'hF, 0, 2'd0, 0, acc);
    chk("mid_level", 64'(ifc.fifo_level), 3);
    do_reset();

    // Sidebands: two-beat packet.
    step(1, 32'hA5A5_0001, 4'hF, 0, 2'b01, 0, acc);
    chk("sb_head_keep", 64'(ifc.bk_keep), 64'hF);
    step(1, 32'hA5A5_0002, 4'h3, 1, 2'b10, 0, acc);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, acc);
`ifdef AXIS_SLV_PKT_CNT_EN
    chk("sb_pkt_cnt", 64'(ifc.pkt_cnt), 1);
`else
    chk("sb_pkt_cnt", 64'(ifc.pkt_cnt), 0);
`endif

    // Wrap: 3*DEPTH+1 beats with random upstream gaps and backend stalls.
    sent = 0; cyc = 0;
    while ((sent < 3 * DP + 1 || m_q.size() != 0) && cyc < 400) begin
      step((sent < 3 * DP + 1) && ($urandom_range(0, 3) != 0), 32'h5000 + 32'(sent),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 2) != 0), acc);
      if (acc) sent++;
      cyc++;
    end
    chk("wrap_done", 64'(sent == 3 * DP + 1 && m_q.size() == 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
